// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial transmit path.
package serial_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_shifter_if.sv
// Word handshake and serial line status bundle for serial_tx_shifter.
interface serial_tx_shifter_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              txd;
  logic              busy;
  logic              done;

  modport master (
    output din, din_valid,
    input  din_ready, txd, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, txd, busy, done
  );

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rest,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB-first, stop bit,
// each held CLKS_PER_BIT clocks.
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rest,
  serial_tx_shifter_if.slave  bus
);

  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  // Index of the bit that becomes LSB after the next shift (guarded for DATA_W=1).
  localparam int unsigned NEXT_IDX = (DATA_W > 1) ? 1 : 0;

  tx_state_t         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BW-1:0]     bitcnt_q;
  logic              txd_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              tick_clear;
  logic              accept;

  // Counter sits at zero in IDLE, so every bit period starts aligned to its state entry.
  assign tick_clear = (state_q == IDLE);
  assign accept     = bus.din_valid && bus.din_ready;

  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk   (clk),
    .rest  (rest),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      txd_q    <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q <= bus.din;
            state_q <= START;
            txd_q   <= START_LEVEL;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q  <= DATA;
            bitcnt_q <= '0;
            txd_q    <= shreg_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg_q  <= shreg_q >> 1;
            bitcnt_q <= bitcnt_q + BW'(1);
            if (bitcnt_q == LAST_BIT) begin
              state_q <= STOP;
              txd_q   <= STOP_LEVEL;
            end else begin
              txd_q <= shreg_q[NEXT_IDX];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            txd_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.din_ready = (state_q == IDLE);
  assign bus.txd       = txd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Self-checking bench for serial_tx_shifter: directed and random frames against a line model.
module tb_serial_tx_shifter;

  localparam int unsigned DW   = 8;
  localparam int unsigned CPB  = 4;
  localparam int unsigned DW1  = 4;
  localparam int unsigned CPB1 = 1;

  logic clk;
  logic rest;
  logic rest1;
  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  serial_tx_shifter_if #(.DATA_W(DW))  bus_a ();
  serial_tx_shifter_if #(.DATA_W(DW1)) bus_b ();

  serial_tx_shifter #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) u_dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus_a)
  );

  serial_tx_shifter #(
    .DATA_W       (DW1),
    .CLKS_PER_BIT (CPB1)
  ) u_dut1 (
    .clk  (clk),
    .rest (rest1),
    .bus  (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level per cycle from the accept edge onward: start, data LSB-first, stop.
  function automatic void frame_line(input logic [31:0] word, input int dw, input int cpb);
    exp_q.delete();
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++)
      for (int c = 0; c < cpb; c++) exp_q.push_back(word[i]);
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b1);
  endfunction

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_txd", bus_a.txd, 1);
      chk("idle_busy", bus_a.busy, 0);
      chk("idle_ready", bus_a.din_ready, 1);
      chk("idle_done", bus_a.done, 0);
    end
  endtask

  // mode 0: drop valid after accept; 1: hold valid with nxt; 2: toggle valid with nxt mid-frame.
  task automatic send_a(input logic [DW-1:0] word, input int mode, input logic [DW-1:0] nxt,
                        input int abort_at);
    int waitc;
    waitc = 0;
    bus_a.din       = word;
    bus_a.din_valid = 1'b1;
    while (bus_a.din_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) begin
      chk("ready_timeout", bus_a.din_ready, 1);
      bus_a.din_valid = 1'b0;
      return;
    end
    frame_line(word, DW, CPB);
    @(posedge clk);
    @(negedge clk);
    if (mode == 0) bus_a.din_valid = 1'b0;
    else           bus_a.din = nxt;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == abort_at) begin
        #2 rest = 1'b1;
        #1;
        chk("abort_txd", bus_a.txd, 1);
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_ready", bus_a.din_ready, 1);
        @(negedge clk);
        chk("abort_done", bus_a.done, 0);
        bus_a.din_valid = 1'b0;
        rest = 1'b0;
        return;
      end
      chk("frame_txd", bus_a.txd, exp_q[k]);
      chk("frame_busy", bus_a.busy, 1);
      chk("frame_ready", bus_a.din_ready, 0);
      chk("frame_done", bus_a.done, 0);
      if (mode == 2)
        bus_a.din_valid = (k == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("end_done", bus_a.done, 1);
    chk("end_busy", bus_a.busy, 0);
    chk("end_txd", bus_a.txd, 1);
    chk("end_ready", bus_a.din_ready, 1);
  endtask

  task automatic send_b(input logic [DW1-1:0] word);
    bus_b.din       = word;
    bus_b.din_valid = 1'b1;
    chk("b_ready", bus_b.din_ready, 1);
    frame_line(word, DW1, CPB1);
    @(posedge clk);
    @(negedge clk);
    bus_b.din_valid = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk("b_txd", bus_b.txd, exp_q[k]);
      chk("b_busy", bus_b.busy, 1);
      chk("b_done", bus_b.done, 0);
      @(negedge clk);
    end
    chk("b_end_done", bus_b.done, 1);
    chk("b_end_txd", bus_b.txd, 1);
    @(negedge clk);
    chk("b_after_done", bus_b.done, 0);
  endtask

  initial begin
    logic [DW-1:0]  w;
    logic [DW1-1:0] wb;
    rest            = 1'b1;
    rest1           = 1'b1;
    bus_a.din       = 8'hFF;
    bus_a.din_valid = 1'b1;
    bus_b.din       = '0;
    bus_b.din_valid = 1'b0;

    // Valid held through reset must not start a frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_txd", bus_a.txd, 1);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_ready", bus_a.din_ready, 1);
      chk("rst_done", bus_a.done, 0);
    end
    bus_a.din_valid = 1'b0;
    rest            = 1'b0;
    rest1           = 1'b0;
    idle_a(4);

    send_a(8'hA5, 0, 8'h00, -1);
    idle_a(2);

    // Back-to-back: second word taken in the done cycle.
    send_a(8'h00, 1, 8'hFF, -1);
    send_a(8'hFF, 0, 8'h00, -1);
    idle_a(1);

    // Activity while busy is ignored and nothing is queued.
    send_a(8'hC3, 2, 8'h3C, -1);
    idle_a(3);
    send_a(8'h3C, 0, 8'h00, -1);
    idle_a(1);

    // Abort during data bit 3 (cycles 16..19 after accept).
    send_a(8'h5A, 0, 8'h00, 4 + 3 * CPB + 1);
    idle_a(3);
    send_a(8'h81, 0, 8'h00, -1);

    for (int r = 0; r < 6; r++) begin
      w = DW'($urandom);
      send_a(w, 0, 8'h00, -1);
      idle_a(int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    send_b(4'b1001);
    for (int r = 0; r < 3; r++) begin
      wb = DW1'($urandom);
      send_b(wb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
